// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one 16-function combinational ALU among N_REQ
// requesters. A round-robin grant picks the next requester. Its opcode and
// operands are held for ALU_LAT execute cycles. The result is then returned
// to that requester through a valid/ready handshake.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN selects fixed priority, where
// the lowest index wins. The round-robin pointer then stays at 0.
module alu_share_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ALU_LAT    = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [4*N_REQ-1:0]          req_op,
  input  logic [DATA_WIDTH*N_REQ-1:0] req_a,
  input  logic [DATA_WIDTH*N_REQ-1:0] req_b,
  output logic [15:0]                 alu_func,
  output logic [DATA_WIDTH-1:0]       alu_a,
  output logic [DATA_WIDTH-1:0]       alu_b,
  output logic                        alu_start,
  input  logic [DATA_WIDTH-1:0]       alu_result,
  output logic [N_REQ-1:0]            rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_WIDTH-1:0]       rsp_data,
  output logic                        busy
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // Context of the operation in flight.
  typedef struct packed {
    logic [IW-1:0] id;
    logic [3:0]    op;
  } cap_t;

  // Same bit layout as the flat ports, so these are plain re-typed views.
  logic [N_REQ-1:0][3:0]            op_v;
  logic [N_REQ-1:0][DATA_WIDTH-1:0] a_v, b_v;
  assign op_v = req_op;
  assign a_v  = req_a;
  assign b_v  = req_b;

  state_t        state, state_n;
  cap_t          cap;
  logic [CW-1:0] cnt;
  logic [IW-1:0] rr_ptr, grant_id, idx;
  logic          found;

  // Round-robin search: the first valid requester at or after rr_ptr.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    idx      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IW'((int'(rr_ptr) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        grant_id = idx;
      end
    end
  end

  // Next state and per-state outputs.
  always_comb begin
    state_n   = state;
    req_ready = '0;
    alu_func  = '0;
    alu_start = 1'b0;
    rsp_valid = '0;
    case (state)
      IDLE: begin
        // Gated by reset so that a held reset shows no grant.
        if (found && !reset) req_ready[grant_id] = 1'b1;
        if (found) state_n = EXEC;
      end
      EXEC: begin
        alu_func[cap.op] = 1'b1;
        alu_start        = (cnt == CW'(ALU_LAT - 1));
        if (cnt == '0) state_n = RESP;
      end
      RESP: begin
        rsp_valid[cap.id] = 1'b1;
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // State, capture registers, execute countdown and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cap      <= '0;
      cnt      <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      rsp_data <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (found) begin
          cap   <= '{id: grant_id, op: op_v[grant_id]};
          alu_a <= a_v[grant_id];
          alu_b <= b_v[grant_id];
          cnt   <= CW'(ALU_LAT - 1);
        end
        EXEC: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else           rsp_data <= alu_result;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Fixed priority: the search always starts at requester 0.
  assign rr_ptr = '0;
`else
  // After each completed response, move the pointer to the requester after the winner.
  always_ff @(posedge clk) begin
    if (reset) rr_ptr <= '0;
    else if (state == RESP && rsp_ready)
      rr_ptr <= (int'(cap.id) == N_REQ - 1) ? '0 : cap.id + 1'b1;
  end
`endif

endmodule
